// File: rtl/disp_scan_ctrl.sv
// Four-digit 7-segment scan controller with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  LES,
  output logic        upd_ack,
  output logic        frame_start,
  output logic [3:0]  AN,
  output logic [3:0]  digit,
  output logic        point_o,
  output logic        le_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK);

  typedef struct packed {
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
  } disp_buf_t;

  localparam disp_buf_t BUF_RST = '{
    hexs:   16'h0000,
    points: 4'h0,
    les:    4'hF
  };

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  disp_buf_t     act_q;
  disp_buf_t     pend_q;
  disp_buf_t     in_buf;
  logic          pend_vld;

  logic          slot_end;
  logic          frame_end;
  logic          commit;
  logic [3:0]    lz_blank;
  logic [3:0]    nib_nxt;
  logic          pt_nxt;
  logic          le_nxt;
  logic [3:0]    an_nxt;

  assign in_buf    = '{hexs: hexs, points: points, les: LES};
  assign slot_end  = (presc == P_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign commit    = frame_end && (pend_vld || load);

`ifdef DISP_SCAN_LZB_EN
  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (act_q.hexs[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (act_q.hexs[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (act_q.hexs[7:4] == 4'h0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  always_comb begin
    nib_nxt = act_q.hexs[{idx, 2'b00} +: 4];
    pt_nxt  = act_q.points[idx] & ~lz_blank[idx];
    le_nxt  = act_q.les[idx] | lz_blank[idx];
    an_nxt  = 4'b1111;
    if (presc >= P_BLANK) begin
      an_nxt[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Inputs arriving on the frame boundary skip the pending stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= BUF_RST;
      pend_q   <= BUF_RST;
      pend_vld <= 1'b0;
    end else if (commit) begin
      act_q    <= load ? in_buf : pend_q;
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_q   <= in_buf;
      pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AN          <= 4'b1111;
      digit       <= 4'h0;
      point_o     <= 1'b0;
      le_o        <= 1'b1;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      AN          <= an_nxt;
      digit       <= nib_nxt;
      point_o     <= pt_nxt;
      le_o        <= le_nxt;
      upd_ack     <= commit;
      frame_start <= (presc == '0) && (idx == 2'd0);
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl at SCAN_DIV=8, BLANK=2.
// Define DISP_SCAN_LZB_EN for both DUT and bench to check blanking.
module tb_disp_scan_ctrl;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hexs = 16'h0;
  logic [3:0]  points = 4'h0;
  logic [3:0]  LES = 4'h0;
  logic        upd_ack;
  logic        frame_start;
  logic [3:0]  AN;
  logic [3:0]  digit;
  logic        point_o;
  logic        le_o;

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .hexs(hexs),
    .points(points),
    .LES(LES),
    .upd_ack(upd_ack),
    .frame_start(frame_start),
    .AN(AN),
    .digit(digit),
    .point_o(point_o),
    .le_o(le_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k = 0;
  int cyc = 0;

  logic [15:0] m_hex;
  logic [3:0]  m_pt;
  logic [3:0]  m_le;
  logic [15:0] p_hex;
  logic [3:0]  p_pt;
  logic [3:0]  p_le;
  logic        m_pend;

  logic [11:0] sb[$];

  // {upd_ack, frame_start, AN, digit, point_o, le_o}
  task automatic step(input logic r, input logic ld,
                      input logic [15:0] h, input logic [3:0] pt,
                      input logic [3:0] ls, input string tag);
    logic [11:0] e;
    logic [11:0] got;
    int pos, slot, ph;
    logic [3:0] an, dg;
    logic po, le, fs, ack;
    rst = r; load = ld; hexs = h; points = pt; LES = ls;
    if (r) begin
      e = {1'b0, 1'b0, 4'b1111, 4'h0, 1'b0, 1'b1};
      m_hex = 16'h0; m_pt = 4'h0; m_le = 4'hF;
      p_hex = 16'h0; p_pt = 4'h0; p_le = 4'hF;
      m_pend = 1'b0;
      k = 0;
    end else begin
      pos  = k % FRAME;
      slot = pos / SD;
      ph   = pos % SD;
      an = (ph < BL) ? 4'b1111 : ~(4'b0001 << slot);
      dg = 4'((m_hex >> (4 * slot)) & 16'hF);
      po = m_pt[slot];
      le = m_le[slot];
`ifdef DISP_SCAN_LZB_EN
      if (slot != 0 && (m_hex >> (4 * slot)) == 16'h0) begin
        le = 1'b1;
        po = 1'b0;
      end
`endif
      fs  = (pos == 0);
      ack = 1'b0;
      if (pos == FRAME - 1 && (m_pend || ld)) begin
        ack = 1'b1;
        if (ld) begin
          m_hex = h; m_pt = pt; m_le = ls;
        end else begin
          m_hex = p_hex; m_pt = p_pt; m_le = p_le;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        p_hex = h; p_pt = pt; p_le = ls;
        m_pend = 1'b1;
      end
      e = {ack, fs, an, dg, po, le};
      k++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = {upd_ack, frame_start, AN, digit, point_o, le_o};
    e = sb.pop_front();
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, e);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), tag);
    end
  endtask

  task automatic idle_to(input int target, input string tag);
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), tag);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, "reset");
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, "reset");
    idle(2 * FRAME + 3, "idle_scan");

    idle_to(12, "pre_load");
    step(1'b0, 1'b1, 16'h1A3F, 4'b0100, 4'h0, "load_1a3f");
    idle(2 * FRAME + 4, "show_1a3f");

    idle_to(5, "pre_two");
    step(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0, "load_1111");
    idle(6, "between");
    step(1'b0, 1'b1, 16'h2222, 4'h3, 4'h0, "load_2222");
    idle(2 * FRAME, "show_2222");

    idle_to(FRAME - 1, "pre_wrap");
    step(1'b0, 1'b1, 16'hBEEF, 4'b1000, 4'h0, "load_wrap");
    idle(2 * FRAME + 2, "show_beef");

    idle_to(2 * SD + 3, "pre_rst");
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, "mid_rst");
    idle(FRAME + 5, "after_rst");

    step(1'b0, 1'b1, 16'h0050, 4'b1001, 4'h0, "load_0050");
    idle(2 * FRAME + 2, "show_0050");

    step(1'b0, 1'b1, 16'h0007, 4'h0, 4'b0010, "load_0007");
    idle(2 * FRAME + 2, "show_0007");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
